// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the int8 convolution engine and its
// downstream stages (FSM state encoding, memory depth default, address
// width derivation, int8 saturation constants, pooling config payload).
package conv_pkg;

    // Two-bit engine state encoding shared across the convolution pipeline.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
    } state_e;

    localparam int unsigned DSIZE_DEF = 1024;

    localparam logic [7:0] INT8_MIN = 8'h80;
    localparam logic [7:0] INT8_MAX = 8'h7F;

    // Byte address width: one extra bit so base+offset sums never wrap silently.
    function automatic int unsigned calc_aw(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Pooling configuration captured on an accepted start.
    typedef struct packed {
        logic [7:0] pitch;
        logic [7:0] out_w;
        logic [7:0] out_h;
        logic [3:0] pool_w;
        logic [3:0] pool_h;
    } pool_cfg_t;

endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: nested window/output counters for non-overlapping pooling.
// Produces the registered source byte address for the current element, the
// pooled-output write index, and last-element / last-window flags.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   i_clear         reset all counters (accepted start)
//   i_adv           step to the next element (one per RUN cycle)
//   i_cfg           latched pooling configuration
//   o_src_addr      byte address of the element being read this cycle
//   o_po_idx        pooled-output index of the current window
//   o_last_elem_c   current element closes its window
//   o_last_win_c    current element closes the final window
module pool_addr_gen
    import conv_pkg::*;
#(
    parameter int unsigned AW = 11,
    parameter int unsigned IW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_adv,
    input  pool_cfg_t     i_cfg,
    output logic [AW-1:0] o_src_addr,
    output logic [IW-1:0] o_po_idx,
    output logic          o_last_elem_c,
    output logic          o_last_win_c
);

    logic [3:0]    r_wx, r_wy;
    logic [7:0]    r_ox, r_oy;
    logic [AW-1:0] r_x;        // ox*pool_w + wx
    logic [AW-1:0] r_row;      // in_pitch*(oy*pool_h + wy)
    logic [AW-1:0] r_win_row;  // in_pitch*(oy*pool_h), first row of window band
    logic [AW-1:0] r_src_addr;
    logic [IW-1:0] r_po_idx;

    logic [3:0]    w_wx_nxt, w_wy_nxt;
    logic [7:0]    w_ox_nxt, w_oy_nxt;
    logic [AW-1:0] w_x_nxt, w_row_nxt, w_win_row_nxt;

    logic w_wx_end, w_wy_end, w_ox_end, w_oy_end;
    logic [AW-1:0] w_pitch, w_pw_m1;

    assign w_wx_end = (r_wx == i_cfg.pool_w - 4'd1);
    assign w_wy_end = (r_wy == i_cfg.pool_h - 4'd1);
    assign w_ox_end = (r_ox == i_cfg.out_w - 8'd1);
    assign w_oy_end = (r_oy == i_cfg.out_h - 8'd1);

    assign w_pitch  = AW'(i_cfg.pitch);
    assign w_pw_m1  = AW'(i_cfg.pool_w) - AW'(1);

    assign o_last_elem_c = w_wx_end & w_wy_end;
    assign o_last_win_c  = o_last_elem_c & w_ox_end & w_oy_end;
    assign o_src_addr    = r_src_addr;
    assign o_po_idx      = r_po_idx;

    // Incremental address update: no multipliers, just adds of pitch/stride.
    always_comb begin
        w_wx_nxt      = r_wx;
        w_wy_nxt      = r_wy;
        w_ox_nxt      = r_ox;
        w_oy_nxt      = r_oy;
        w_x_nxt       = r_x;
        w_row_nxt     = r_row;
        w_win_row_nxt = r_win_row;
        if (i_clear) begin
            w_wx_nxt      = '0;
            w_wy_nxt      = '0;
            w_ox_nxt      = '0;
            w_oy_nxt      = '0;
            w_x_nxt       = '0;
            w_row_nxt     = '0;
            w_win_row_nxt = '0;
        end else if (i_adv) begin
            if (!w_wx_end) begin
                w_wx_nxt = r_wx + 4'd1;
                w_x_nxt  = r_x + AW'(1);
            end else if (!w_wy_end) begin
                // next row inside the window: rewind x to window start
                w_wx_nxt  = '0;
                w_wy_nxt  = r_wy + 4'd1;
                w_x_nxt   = r_x - w_pw_m1;
                w_row_nxt = r_row + w_pitch;
            end else if (!w_ox_end) begin
                // next window to the right: x continues, rows rewind to band top
                w_wx_nxt  = '0;
                w_wy_nxt  = '0;
                w_ox_nxt  = r_ox + 8'd1;
                w_x_nxt   = r_x + AW'(1);
                w_row_nxt = r_win_row;
            end else if (!w_oy_end) begin
                // next band of windows starts on the row after the current one
                w_wx_nxt      = '0;
                w_wy_nxt      = '0;
                w_ox_nxt      = '0;
                w_oy_nxt      = r_oy + 8'd1;
                w_x_nxt       = '0;
                w_row_nxt     = r_row + w_pitch;
                w_win_row_nxt = r_row + w_pitch;
            end else begin
                w_wx_nxt      = '0;
                w_wy_nxt      = '0;
                w_ox_nxt      = '0;
                w_oy_nxt      = '0;
                w_x_nxt       = '0;
                w_row_nxt     = '0;
                w_win_row_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wx       <= '0;
            r_wy       <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_x        <= '0;
            r_row      <= '0;
            r_win_row  <= '0;
            r_src_addr <= '0;
        end else if (i_clear || i_adv) begin
            r_wx       <= w_wx_nxt;
            r_wy       <= w_wy_nxt;
            r_ox       <= w_ox_nxt;
            r_oy       <= w_oy_nxt;
            r_x        <= w_x_nxt;
            r_row      <= w_row_nxt;
            r_win_row  <= w_win_row_nxt;
            r_src_addr <= w_x_nxt + w_row_nxt;
        end
    end

    // Pooled-output index advances once per completed window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_po_idx <= '0;
        end else if (i_clear) begin
            r_po_idx <= '0;
        end else if (i_adv && o_last_elem_c) begin
            r_po_idx <= r_po_idx + IW'(1);
        end
    end

endmodule

// File: rtl/maxpool2d.sv
// maxpool2d: non-overlapping P_W x P_H signed int8 max pooling over the
// convolution output map, result stored in a local byte memory (PO).
// Optional build macro MAXPOOL_RELU_EN: clamp negative source bytes to 0
// before the compare and start each window at 0 instead of -128.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   in_pitch        source row pitch in bytes
//   out_width       pooled map width;  out_height  pooled map height
//   pool_w, pool_h  window size and stride (1..15)
//   src_addr        byte address into the source map (registered)
//   src_data        word read at src_addr, element in bits [7:0]
//   po_addr/po_data combinational 32-bit little-endian read of PO
//   start           one-cycle start pulse; busy high in RUN; done pulse
module maxpool2d
    import conv_pkg::*;
#(
    parameter  int unsigned DSIZE = DSIZE_DEF,
    localparam int unsigned AW    = calc_aw(DSIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_pitch,
    input  logic [7:0]    out_width,
    input  logic [7:0]    out_height,
    input  logic [3:0]    pool_w,
    input  logic [3:0]    pool_h,
    output logic [AW-1:0] src_addr,
    input  logic [31:0]   src_data,
    input  logic [AW-1:0] po_addr,
    output logic [31:0]   po_data,
    input  logic          start,
    output logic          busy,
    output logic          done
);

    localparam int unsigned IW = $clog2(DSIZE);

`ifdef MAXPOOL_RELU_EN
    localparam logic [7:0] MAX_INIT = 8'h00;
`else
    localparam logic [7:0] MAX_INIT = INT8_MIN;
`endif

    state_e        r_state, w_state_nxt;
    pool_cfg_t     r_cfg, w_cfg_in;
    logic          r_busy, r_done;
    logic          w_busy_nxt, w_done_nxt;
    logic          w_accept, w_adv, w_cfg_valid;
    logic          w_last_elem, w_last_win;
    logic [IW-1:0] w_po_idx;
    logic [7:0]    r_max;
    logic [7:0]    w_elem, w_max_new;
    logic [7:0]    r_po [DSIZE];

    assign w_cfg_in = '{pitch: in_pitch, out_w: out_width, out_h: out_height,
                        pool_w: pool_w, pool_h: pool_h};
    assign w_cfg_valid = (out_width != 8'd0) && (out_height != 8'd0) &&
                         (pool_w != 4'd0) && (pool_h != 4'd0);

    pool_addr_gen #(
        .AW (AW),
        .IW (IW)
    ) u_addr_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (w_accept),
        .i_adv         (w_adv),
        .i_cfg         (r_cfg),
        .o_src_addr    (src_addr),
        .o_po_idx      (w_po_idx),
        .o_last_elem_c (w_last_elem),
        .o_last_win_c  (w_last_win)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start && w_cfg_valid) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last_win)           w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs; an invalid config answers start with an immediate done.
    always_comb begin
        w_accept   = 1'b0;
        w_adv      = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_cfg_valid) begin
                        w_accept   = 1'b1;
                        w_busy_nxt = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                w_adv = 1'b1;
                if (w_last_win) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_busy_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg <= '0;
        end else if (w_accept) begin
            r_cfg <= w_cfg_in;
        end
    end

`ifdef MAXPOOL_RELU_EN
    assign w_elem = src_data[7] ? 8'h00 : src_data[7:0];
`else
    assign w_elem = src_data[7:0];
`endif

    assign w_max_new = ($signed(w_elem) > $signed(r_max)) ? w_elem : r_max;

    // Running max restarts at the window boundary on the same edge as the PO write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= MAX_INIT;
        end else if (w_accept) begin
            r_max <= MAX_INIT;
        end else if (w_adv) begin
            r_max <= w_last_elem ? MAX_INIT : w_max_new;
        end
    end

    // Pooled output memory; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_adv && w_last_elem) begin
            r_po[w_po_idx] <= w_max_new;
        end
    end

    logic [AW-1:0] w_ra0, w_ra1, w_ra2, w_ra3;
    assign w_ra0 = po_addr;
    assign w_ra1 = po_addr + AW'(1);
    assign w_ra2 = po_addr + AW'(2);
    assign w_ra3 = po_addr + AW'(3);

    assign po_data = {r_po[w_ra3[IW-1:0]], r_po[w_ra2[IW-1:0]],
                      r_po[w_ra1[IW-1:0]], r_po[w_ra0[IW-1:0]]};

    // Upper source bytes and the address carry bit are not needed here.
    logic w_unused;
    assign w_unused = ^{src_data[31:8], w_ra0[AW-1], w_ra1[AW-1],
                        w_ra2[AW-1], w_ra3[AW-1]};

endmodule

// File: tb/tb_maxpool2d.sv
// tb_maxpool2d: directed bench for maxpool2d with a behavioural source memory.
module tb_maxpool2d;

    localparam int unsigned DSIZE = 1024;
    localparam int unsigned AW    = 11;

    logic          clk;
    logic          rst_n;
    logic [7:0]    in_pitch, out_width, out_height;
    logic [3:0]    pool_w, pool_h;
    logic [AW-1:0] src_addr;
    logic [31:0]   src_data;
    logic [AW-1:0] po_addr;
    logic [31:0]   po_data;
    logic          start, busy, done;

    logic [7:0] src_mem [DSIZE];

    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;
    int bad_col  = 0;

    maxpool2d #(.DSIZE(DSIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_pitch   (in_pitch),
        .out_width  (out_width),
        .out_height (out_height),
        .pool_w     (pool_w),
        .pool_h     (pool_h),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .po_addr    (po_addr),
        .po_data    (po_data),
        .start      (start),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] src_rd(input logic [AW-1:0] a);
        logic [9:0] i;
        i = a[9:0];
        return src_mem[i];
    endfunction

    always_comb begin
        src_data = {src_rd(src_addr + 11'd3), src_rd(src_addr + 11'd2),
                    src_rd(src_addr + 11'd1), src_rd(src_addr)};
    end

    // Counts element reads and reads landing in columns 4..5 of a pitch-6 map.
    always @(posedge clk) begin
        if (busy === 1'b1) begin
            rd_cnt <= rd_cnt + 1;
            if ((int'(src_addr) % 6) >= 4) bad_col <= bad_col + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [7:0] p, input logic [7:0] ow, input logic [7:0] oh,
                           input logic [3:0] pw, input logic [3:0] ph);
        in_pitch = p; out_width = ow; out_height = oh; pool_w = pw; pool_h = ph;
    endtask

    task automatic po_check(input string tag, input logic [31:0] exp);
        po_addr = '0;
        #1;
        check(tag, po_data, exp);
    endtask

    // Pulse start, count edges until done, verify busy profile and done width.
    task automatic do_run(input string tag, input int exp_cycles, input logic exp_busy);
        int c;
        int busy_bad;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        set_cfg(8'd9, 8'd9, 8'd9, 4'd9, 4'd9);  // must not affect a running job
        c = 0;
        busy_bad = 0;
        while (done !== 1'b1 && c < 300) begin
            if (busy !== exp_busy) busy_bad++;
            @(negedge clk);
            c++;
        end
        check({tag, "_cycles"}, 32'(c), 32'(exp_cycles));
        check({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int rd0, bad0, c, dn;
        rst_n = 1'b0;
        start = 1'b0;
        po_addr = '0;
        set_cfg(8'd4, 8'd2, 8'd2, 4'd2, 4'd2);
        for (int i = 0; i < DSIZE; i++) src_mem[i] = 8'h00;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_src_addr", 32'(src_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 4x4 ramp, 2x2 pool
        for (int i = 0; i < 16; i++) src_mem[i] = 8'(i);
        set_cfg(8'd4, 8'd2, 8'd2, 4'd2, 4'd2);
        do_run("ramp", 16, 1'b1);
        po_check("ramp_po", 32'h0F0D0705);

        // -128 fill with one -1 per window
        for (int i = 0; i < 16; i++) src_mem[i] = 8'h80;
        src_mem[1] = 8'hFF; src_mem[6] = 8'hFF; src_mem[12] = 8'hFF; src_mem[15] = 8'hFF;
        set_cfg(8'd4, 8'd2, 8'd2, 4'd2, 4'd2);
        do_run("neg", 16, 1'b1);
`ifdef MAXPOOL_RELU_EN
        po_check("neg_po", 32'h00000000);
`else
        po_check("neg_po", 32'hFFFFFFFF);
`endif

        // pitch 6, only 4 columns pooled; columns 4..5 hold bait values
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 6; cc++)
                src_mem[r*6+cc] = (cc < 4) ? 8'(10*r + cc) : 8'h7F;
        set_cfg(8'd6, 8'd2, 8'd2, 4'd2, 4'd2);
        rd0 = rd_cnt; bad0 = bad_col;
        do_run("pitch6", 16, 1'b1);
        po_check("pitch6_po", 32'h211F0D0B);
        check("pitch6_reads", 32'(rd_cnt - rd0), 32'd16);
        check("pitch6_badcol", 32'(bad_col - bad0), 32'd0);

        // 3x1 windows, mixed signs
        src_mem[0] = 8'd10; src_mem[1] = 8'hFD; src_mem[2] = 8'd7;
        src_mem[3] = 8'hCE; src_mem[4] = 8'd20; src_mem[5] = 8'd20;
        set_cfg(8'd6, 8'd2, 8'd1, 4'd3, 4'd1);
        do_run("w3h1", 6, 1'b1);
        po_check("w3h1_po", 32'h211F140A);

        // invalid config: immediate done, no busy, PO untouched
        set_cfg(8'd4, 8'd0, 8'd2, 4'd2, 4'd2);
        do_run("invalid", 0, 1'b0);
        po_check("invalid_po", 32'h211F140A);

        // reset in the middle of a 2x2-out run, then rerun
        for (int i = 0; i < 16; i++) src_mem[i] = 8'(15 - i);
        set_cfg(8'd4, 8'd2, 8'd2, 4'd2, 4'd2);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        po_check("midrun_po", 32'h211F140F);
        check("midrun_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_src_addr", 32'(src_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);
        po_check("abort_po_kept", 32'h211F140F);
        do_run("rerun", 16, 1'b1);
        po_check("rerun_po", 32'h05070D0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
